// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the 64-word combinational ROM and
// registers the IF/ID latch. Handles hazard stalls, branch redirect/flush, and hands the
// ROM port to a debug reader while halted.
// Ports: clk/rst (sync, active-high); run/halt_req (FSM control); stall/br_taken/br_target
// (pipeline control); rom_a/rom_inst (ROM port); if_inst/if_pc/if_valid (IF/ID latch);
// pc (fetch PC); dbg_req/dbg_addr/dbg_gnt/dbg_data (debug read port); state (FSM state).
module inst_fetch_ctrl #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt_req,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_inst,
  output logic [DW-1:0] if_inst,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic [AW-1:0] pc,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_data,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t cur_state, nxt_state;

  logic [AW-1:0] pc_q;
  logic [DW-1:0] inst_q;
  logic [AW-1:0] ifpc_q;
  logic          valid_q;
  logic          gnt_q;
  logic [DW-1:0] dbg_q;

  // Per-edge datapath actions decoded from the current state and pipeline inputs.
  logic do_redirect;  // load pc from br_target and flush IF/ID
  logic do_fetch;     // capture ROM word into IF/ID and advance pc
  logic do_flush;     // clear if_valid without touching pc
  logic dbg_rd;       // debug read completes this edge

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    do_redirect = 1'b0;
    do_fetch    = 1'b0;
    do_flush    = 1'b0;
    dbg_rd      = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (run) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        // br_taken beats halt_req beats stall; a branch alongside a halt still
        // redirects so the resume point is the branch target.
        if (br_taken) begin
          do_redirect = 1'b1;
        end else if (halt_req) begin
          do_flush = 1'b1;
        end else if (!stall) begin
          do_fetch = 1'b1;
        end
        if (halt_req) nxt_state = S_HALTED;
      end
      S_HALTED: begin
        // A read requested on the resume edge still completes: rom_a already
        // points at dbg_addr for this whole cycle.
        dbg_rd = dbg_req;
        if (run && !halt_req) nxt_state = S_FETCH;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= 1'b0;
      dbg_q   <= '0;
    end else begin
      gnt_q <= dbg_rd;
      if (dbg_rd) dbg_q <= rom_inst;
      if (do_redirect) begin
        pc_q    <= br_target;
        valid_q <= 1'b0;
      end else if (do_flush) begin
        valid_q <= 1'b0;
      end else if (do_fetch) begin
        inst_q  <= rom_inst;
        ifpc_q  <= pc_q;
        valid_q <= 1'b1;
        pc_q    <= pc_q + {{(AW-1){1'b0}}, 1'b1};  // wraps at 2^AW
      end
    end
  end

  assign rom_a    = (cur_state == S_HALTED && dbg_req) ? dbg_addr : pc_q;
  assign if_inst  = inst_q;
  assign if_pc    = ifpc_q;
  assign if_valid = valid_q;
  assign pc       = pc_q;
  assign dbg_gnt  = gnt_q;
  assign dbg_data = dbg_q;
  assign state    = cur_state;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, halt_req, stall, br_taken, dbg_req;
  logic [5:0]  br_target, dbg_addr, rom_a, if_pc, pc;
  logic [31:0] rom_inst, if_inst, dbg_data;
  logic        if_valid, dbg_gnt;
  logic [1:0]  state;

  logic [31:0] rom [64];
  assign rom_inst = rom[rom_a];

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.AW(6), .DW(32), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .rom_a(rom_a), .rom_inst(rom_inst),
    .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid), .pc(pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_data(dbg_data),
    .state(state)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: architectural state of the fetch unit. Mode is kept as the
  // 2-bit code the state port reports.
  localparam logic [1:0] M_IDLE = 2'b00, M_FETCH = 2'b01, M_HALT = 2'b10;
  logic [5:0]  m_pc, m_ifpc;
  logic [31:0] m_inst, m_dbg;
  logic        m_valid, m_gnt;
  logic [1:0]  m_mode;

  function automatic logic [5:0] m_rom_a();
    return (m_mode == M_HALT && dbg_req) ? dbg_addr : m_pc;
  endfunction

  // Advance one clock: compute the model's next state from the current inputs,
  // take the edge, commit, then settle 1 time unit past the edge.
  task automatic tick();
    logic [5:0]  n_pc, n_ifpc;
    logic [31:0] n_inst, n_dbg;
    logic        n_valid, n_gnt;
    logic [1:0]  n_mode;
    n_pc = m_pc; n_ifpc = m_ifpc; n_inst = m_inst; n_dbg = m_dbg;
    n_valid = m_valid; n_gnt = 1'b0; n_mode = m_mode;
    if (rst) begin
      n_pc = 6'd0; n_ifpc = 6'd0; n_inst = 32'd0; n_dbg = 32'd0;
      n_valid = 1'b0; n_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (run) n_mode = M_FETCH;
    end else if (m_mode == M_FETCH) begin
      if (br_taken) begin
        n_pc = br_target; n_valid = 1'b0;
        if (halt_req) n_mode = M_HALT;
      end else if (halt_req) begin
        n_valid = 1'b0; n_mode = M_HALT;
      end else if (!stall) begin
        n_inst = rom[m_pc]; n_ifpc = m_pc; n_valid = 1'b1;
        n_pc = 6'((int'(m_pc) + 1) % 64);
      end
    end else begin
      if (dbg_req) begin
        n_dbg = rom[dbg_addr]; n_gnt = 1'b1;
      end
      if (run && !halt_req) n_mode = M_FETCH;
    end
    @(posedge clk);
    m_pc = n_pc; m_ifpc = n_ifpc; m_inst = n_inst; m_dbg = n_dbg;
    m_valid = n_valid; m_gnt = n_gnt; m_mode = n_mode;
    #1;
  endtask

  task automatic clear_inputs();
    run = 0; halt_req = 0; stall = 0; br_taken = 0; br_target = 0;
    dbg_req = 0; dbg_addr = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); run = 1;
    tick(); tick();
    checks++; if (pc !== 6'd0) $display("FAIL reset_pc: got %h exp 00", pc); else passed++;
    checks++; if (state !== M_IDLE) $display("FAIL reset_state: got %b exp 00", state); else passed++;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'd0 || if_pc !== 6'd0)
      $display("FAIL reset_ifid: got v=%b i=%h p=%h exp 0/0/0", if_valid, if_inst, if_pc); else passed++;
    checks++; if (dbg_gnt !== 1'b0 || dbg_data !== 32'd0)
      $display("FAIL reset_dbg: got g=%b d=%h exp 0/0", dbg_gnt, dbg_data); else passed++;
  endtask

  task automatic test_fetch();
    rst = 0; run = 1;
    tick();
    checks++; if (state !== M_FETCH || pc !== 6'd0)
      $display("FAIL fetch_enter: got st=%b pc=%h exp 01/00", state, pc); else passed++;
    tick();
    checks++; if (if_pc !== 6'd0 || if_valid !== 1'b1 || if_inst !== rom[0])
      $display("FAIL fetch_first: got p=%h v=%b i=%h exp 00/1/%h", if_pc, if_valid, if_inst, rom[0]); else passed++;
    tick();
    checks++; if (if_inst !== 32'h30001043 || if_valid !== 1'b1 || if_pc !== 6'd1)
      $display("FAIL fetch_rom1: got i=%h v=%b p=%h exp 30001043/1/01", if_inst, if_valid, if_pc); else passed++;
    tick();
    checks++; if (pc !== 6'd3 || if_pc !== 6'd2)
      $display("FAIL fetch_seq: got pc=%h if_pc=%h exp 03/02", pc, if_pc); else passed++;
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 6'd3 || if_pc !== 6'd2 || if_valid !== 1'b1)
        $display("FAIL stall_hold%0d: got pc=%h if_pc=%h v=%b exp 03/02/1", i, pc, if_pc, if_valid); else passed++;
    end
    stall = 0;
    tick();
    checks++; if (if_pc !== 6'd3 || pc !== 6'd4)
      $display("FAIL stall_release: got if_pc=%h pc=%h exp 03/04", if_pc, pc); else passed++;
  endtask

  task automatic test_branch();
    stall = 1; br_taken = 1; br_target = 6'h1C;
    tick();
    checks++; if (pc !== 6'h1C || if_valid !== 1'b0)
      $display("FAIL branch_redirect: got pc=%h v=%b exp 1c/0", pc, if_valid); else passed++;
    stall = 0; br_taken = 0;
    tick();
    checks++; if (if_pc !== 6'h1C || if_valid !== 1'b1 || if_inst !== rom[6'h1C])
      $display("FAIL branch_target: got p=%h v=%b i=%h exp 1c/1/%h", if_pc, if_valid, if_inst, rom[6'h1C]); else passed++;
  endtask

  task automatic test_wrap();
    br_taken = 1; br_target = 6'h3E;
    tick();
    br_taken = 0;
    tick();
    checks++; if (pc !== 6'h3F) $display("FAIL wrap_pre: got pc=%h exp 3f", pc); else passed++;
    tick();
    checks++; if (pc !== 6'h00 || if_pc !== 6'h3F || if_inst !== rom[63])
      $display("FAIL wrap: got pc=%h if_pc=%h i=%h exp 00/3f/%h", pc, if_pc, if_inst, rom[63]); else passed++;
  endtask

  task automatic test_halt_dbg();
    logic [5:0] held_pc;
    dbg_req = 1; dbg_addr = 6'h02;
    checks++; if (rom_a !== m_pc) $display("FAIL dbg_fetch_roma: got %h exp %h", rom_a, m_pc); else passed++;
    tick();
    checks++; if (dbg_gnt !== 1'b0 || dbg_data !== 32'd0)
      $display("FAIL dbg_in_fetch: got g=%b d=%h exp 0/0", dbg_gnt, dbg_data); else passed++;
    held_pc = m_pc;
    halt_req = 1; run = 0;
    tick();
    checks++; if (state !== M_HALT || if_valid !== 1'b0 || pc !== held_pc)
      $display("FAIL halt_enter: got st=%b v=%b pc=%h exp 10/0/%h", state, if_valid, pc, held_pc); else passed++;
    checks++; if (rom_a !== 6'h02) $display("FAIL halt_roma: got %h exp 02", rom_a); else passed++;
    tick();
    checks++; if (dbg_gnt !== 1'b1 || dbg_data !== 32'h400010a6)
      $display("FAIL dbg_read: got g=%b d=%h exp 1/400010a6", dbg_gnt, dbg_data); else passed++;
    dbg_req = 0; stall = 1; br_taken = 1; br_target = 6'h11;
    tick();
    checks++; if (dbg_gnt !== 1'b0 || dbg_data !== 32'h400010a6 || pc !== held_pc)
      $display("FAIL halt_hold: got g=%b d=%h pc=%h exp 0/400010a6/%h", dbg_gnt, dbg_data, pc, held_pc); else passed++;
    stall = 0; br_taken = 0;
    run = 1; halt_req = 0; dbg_req = 1; dbg_addr = 6'h05;
    tick();
    checks++; if (state !== M_FETCH || dbg_gnt !== 1'b1 || dbg_data !== rom[5])
      $display("FAIL resume_dbg: got st=%b g=%b d=%h exp 01/1/%h", state, dbg_gnt, dbg_data, rom[5]); else passed++;
    tick();
    checks++; if (dbg_gnt !== 1'b0 || if_pc !== held_pc || if_valid !== 1'b1)
      $display("FAIL resume_fetch: got g=%b if_pc=%h v=%b exp 0/%h/1", dbg_gnt, if_pc, if_valid, held_pc); else passed++;
    dbg_req = 0;
  endtask

  task automatic test_reset_mid();
    run = 1; rst = 1;
    tick();
    checks++; if (state !== M_IDLE || pc !== 6'd0 || if_valid !== 1'b0 || if_pc !== 6'd0 ||
                  if_inst !== 32'd0 || dbg_data !== 32'd0 || dbg_gnt !== 1'b0)
      $display("FAIL reset_mid: got st=%b pc=%h v=%b p=%h i=%h d=%h g=%b exp all zero",
               state, pc, if_valid, if_pc, if_inst, dbg_data, dbg_gnt); else passed++;
    rst = 0;
    tick();
    checks++; if (state !== M_FETCH || pc !== 6'd0)
      $display("FAIL reset_resume: got st=%b pc=%h exp 01/00", state, pc); else passed++;
    tick();
    checks++; if (if_pc !== 6'd0 || if_valid !== 1'b1 || pc !== 6'd1)
      $display("FAIL reset_first: got p=%h v=%b pc=%h exp 00/1/01", if_pc, if_valid, pc); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      run       = ($urandom_range(0, 99) < 40);
      halt_req  = ($urandom_range(0, 99) < 15);
      stall     = ($urandom_range(0, 99) < 25);
      br_taken  = ($urandom_range(0, 99) < 12);
      br_target = 6'($urandom_range(0, 63));
      dbg_req   = ($urandom_range(0, 99) < 50);
      dbg_addr  = 6'($urandom_range(0, 63));
      #1;
      checks++;
      if (rom_a !== m_rom_a()) begin
        errs++;
        if (errs < 10) $display("FAIL rand_roma[%0d]: got %h exp %h", i, rom_a, m_rom_a());
      end else passed++;
      tick();
      checks++;
      if (pc !== m_pc || state !== m_mode || if_valid !== m_valid || dbg_gnt !== m_gnt ||
          dbg_data !== m_dbg || (m_valid && (if_pc !== m_ifpc || if_inst !== m_inst))) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_state[%0d]: got pc=%h st=%b v=%b g=%b d=%h p=%h i=%h exp pc=%h st=%b v=%b g=%b d=%h p=%h i=%h",
                   i, pc, state, if_valid, dbg_gnt, dbg_data, if_pc, if_inst,
                   m_pc, m_mode, m_valid, m_gnt, m_dbg, m_ifpc, m_inst);
      end else passed++;
    end
    clear_inputs(); rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[1] = 32'h30001043;
    rom[2] = 32'h400010a6;
    m_pc = 0; m_ifpc = 0; m_inst = 0; m_dbg = 0; m_valid = 0; m_gnt = 0; m_mode = M_IDLE;
    rst = 1; clear_inputs();
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_wrap();
    test_halt_dbg();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
